// File: rtl/cnn_pkg.sv
// Shared types and constants for the fully-connected layer sequencer and its
// RAM/ROM wrappers.
package cnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  localparam int L1_N_IN    = 401;
  localparam int L1_N_OUT   = 26;
  localparam int L2_N_IN    = 26;
  localparam int L2_N_OUT   = 11;
  localparam int CNN_RD_LAT = 2;

  // Width of a counter that runs 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cnn_delay_line.sv
// Fixed-depth shift register carrying {en, clr, last} accumulator strobes so
// they line up with the RAM/ROM read data.
module cnn_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] d,
  output logic [2:0] q
);

  logic [2:0] pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= d;
      for (int k = 1; k < DEPTH; k++) pipe[k] <= pipe[k-1];
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Address and accumulator-strobe sequencer for one fully-connected layer,
// handing each finished neuron sum to the sigmoid stage via valid/ready.
//
// state | meaning
// IDLE  | waiting for start; rd_en/addresses held at 0
// ISSUE | one aligned input/weight read per cycle, N_IN per neuron
// DRAIN | RD_LAT cycles letting the last reads reach the MAC
// WRITE | res_valid held with res_idx until res_ready
module cnn_layer_sequencer
  import cnn_pkg::*;
#(
  parameter int N_IN   = L1_N_IN,
  parameter int N_OUT  = L1_N_OUT,
  parameter int RD_LAT = CNN_RD_LAT,
  parameter int XW     = 12,
  parameter int WW     = 14,
  parameter int NW     = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [XW-1:0] x_base,
  input  logic [WW-1:0] w_base,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [XW-1:0] x_addr,
  output logic [WW-1:0] w_addr,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          mac_last,
  output logic          res_valid,
  output logic [NW-1:0] res_idx,
  input  logic          res_ready
);

  localparam int IW = cnt_w(N_IN);
  localparam int DW = cnt_w(RD_LAT);
  localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
  localparam logic [NW-1:0] N_LAST = NW'(N_OUT - 1);
  localparam logic [DW-1:0] D_LAST = DW'(RD_LAT - 1);
  localparam logic          ONE_TERM = (N_IN == 1);

  state_t        state;
  logic [IW-1:0] i;
  logic [NW-1:0] n;
  logic [WW-1:0] wp;
  logic [DW-1:0] dcnt;
  logic [XW-1:0] x_base_q;
  logic [WW-1:0] w_base_q;
  logic          clr_q;
  logic          last_q;
  logic [2:0]    dly_q;

  // i and wp index the term currently on the address outputs; wp runs across
  // neurons so each neuron picks up the next row of the weight matrix.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      i         <= '0;
      n         <= '0;
      wp        <= '0;
      dcnt      <= '0;
      x_base_q  <= '0;
      w_base_q  <= '0;
      clr_q     <= 1'b0;
      last_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      x_addr    <= '0;
      w_addr    <= '0;
      res_valid <= 1'b0;
      res_idx   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            x_base_q <= x_base;
            w_base_q <= w_base;
            i        <= '0;
            n        <= '0;
            wp       <= '0;
            rd_en    <= 1'b1;
            x_addr   <= x_base;
            w_addr   <= w_base;
            clr_q    <= 1'b1;
            last_q   <= ONE_TERM;
            busy     <= 1'b1;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wp <= wp + 1'b1;
          if (i == I_LAST) begin
            rd_en  <= 1'b0;
            x_addr <= '0;
            w_addr <= '0;
            clr_q  <= 1'b0;
            last_q <= 1'b0;
            dcnt   <= D_LAST;
            state  <= ST_DRAIN;
          end else begin
            i      <= i + 1'b1;
            x_addr <= x_base_q + XW'(i + 1'b1);
            w_addr <= w_base_q + wp + WW'(1);
            clr_q  <= 1'b0;
            last_q <= ((i + 1'b1) == I_LAST);
          end
        end
        ST_DRAIN: begin
          if (dcnt == '0) begin
            res_valid <= 1'b1;
            res_idx   <= n;
            state     <= ST_WRITE;
          end else begin
            dcnt <= dcnt - 1'b1;
          end
        end
        ST_WRITE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (n == N_LAST) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              n      <= n + 1'b1;
              i      <= '0;
              rd_en  <= 1'b1;
              x_addr <= x_base_q;
              w_addr <= w_base_q + wp;
              clr_q  <= 1'b1;
              last_q <= ONE_TERM;
              state  <= ST_ISSUE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  cnn_delay_line #(.DEPTH(RD_LAT)) u_dly (
    .clk (clk),
    .rst (rst),
    .d   ({rd_en, clr_q, last_q}),
    .q   (dly_q)
  );

  assign mac_en   = dly_q[2];
  assign mac_clr  = dly_q[1];
  assign mac_last = dly_q[0];

  // A layer must not run off the end of either memory.
  always @(posedge clk) begin
    if (rst && state == ST_IDLE && start) begin
      assert ((longint'(w_base) + longint'(N_OUT) * longint'(N_IN) <= (longint'(1) << WW)) &&
              (longint'(x_base) + longint'(N_IN) <= (longint'(1) << XW)));
    end
  end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Bench for cnn_layer_sequencer: a schedule-level layer model is compared
// cycle by cycle against two instances (4x3 and 1x2 layers).
module tb_cnn_layer_sequencer;

  localparam int RD_LAT = 2;
  localparam int XW = 12;
  localparam int WW = 14;
  localparam int NW = 5;
  localparam int A_IN = 4, A_OUT = 3;
  localparam int B_IN = 1, B_OUT = 2;

  typedef struct {
    bit rd;
    int i;
    int x;
    int w;
    bit valid;
    int idx;
    bit busy;
    bit done;
    bit ready;
  } cyc_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, res_ready, sel;
  logic [XW-1:0] x_base;
  logic [WW-1:0] w_base;
  logic          start_a, start_b;

  logic          a_busy, a_done, a_rd, a_clr, a_en, a_last, a_valid;
  logic [XW-1:0] a_x;
  logic [WW-1:0] a_w;
  logic [NW-1:0] a_idx;
  logic          b_busy, b_done, b_rd, b_clr, b_en, b_last, b_valid;
  logic [XW-1:0] b_x;
  logic [WW-1:0] b_w;
  logic [NW-1:0] b_idx;

  logic [6:0]    o_ctrl;
  logic [XW-1:0] o_x;
  logic [WW-1:0] o_w;
  logic [NW-1:0] o_idx;

  int n_asrt = 0;
  int n_fail = 0;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  cnn_layer_sequencer #(.N_IN(A_IN), .N_OUT(A_OUT), .RD_LAT(RD_LAT), .XW(XW), .WW(WW), .NW(NW)) dut (
    .clk(clk), .rst(rst), .start(start_a), .x_base(x_base), .w_base(w_base),
    .busy(a_busy), .done(a_done), .rd_en(a_rd), .x_addr(a_x), .w_addr(a_w),
    .mac_clr(a_clr), .mac_en(a_en), .mac_last(a_last),
    .res_valid(a_valid), .res_idx(a_idx), .res_ready(res_ready)
  );

  cnn_layer_sequencer #(.N_IN(B_IN), .N_OUT(B_OUT), .RD_LAT(RD_LAT), .XW(XW), .WW(WW), .NW(NW)) dut1 (
    .clk(clk), .rst(rst), .start(start_b), .x_base(x_base), .w_base(w_base),
    .busy(b_busy), .done(b_done), .rd_en(b_rd), .x_addr(b_x), .w_addr(b_w),
    .mac_clr(b_clr), .mac_en(b_en), .mac_last(b_last),
    .res_valid(b_valid), .res_idx(b_idx), .res_ready(res_ready)
  );

  // ctrl bit order: {rd_en, mac_en, mac_clr, mac_last, res_valid, busy, done}
  assign o_ctrl = sel ? {b_rd, b_en, b_clr, b_last, b_valid, b_busy, b_done}
                      : {a_rd, a_en, a_clr, a_last, a_valid, a_busy, a_done};
  assign o_x   = sel ? b_x : a_x;
  assign o_w   = sel ? b_w : a_w;
  assign o_idx = sel ? b_idx : a_idx;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    start = 1'b0;
    res_ready = 1'b1;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Runs one layer starting in the current cycle (cycle 0) and checks every
  // cycle through the done cycle, where it returns without advancing.
  task automatic run_layer(input int xb, input int wb, input int stall0,
                           input bit stall_rand, input int pulse_cyc, input bit noise);
    int n_in, n_out, last_c, p;
    int stall[];
    cyc_t tr[$];
    cyc_t t;
    logic [6:0] ectrl;
    logic [XW-1:0] ex;
    logic [WW-1:0] ew;
    logic [NW-1:0] eidx;
    n_in  = sel ? B_IN : A_IN;
    n_out = sel ? B_OUT : A_OUT;
    stall = new[n_out];
    for (int n = 0; n < n_out; n++)
      stall[n] = (n == 0) ? stall0 : (stall_rand ? int'($urandom_range(0, 3)) : 0);

    t = '{default: 0};
    tr.push_back(t);
    for (int n = 0; n < n_out; n++) begin
      for (int i = 0; i < n_in; i++) begin
        t = '{default: 0};
        t.rd = 1; t.i = i; t.busy = 1;
        t.x = (xb + i) % (1 << XW);
        t.w = (wb + n * n_in + i) % (1 << WW);
        t.ready = noise ? 1'($urandom_range(0, 1)) : 1'b1;
        tr.push_back(t);
      end
      for (int d = 0; d < RD_LAT; d++) begin
        t = '{default: 0};
        t.busy = 1;
        t.ready = noise ? 1'($urandom_range(0, 1)) : 1'b1;
        tr.push_back(t);
      end
      for (int s = 0; s <= stall[n]; s++) begin
        t = '{default: 0};
        t.valid = 1; t.idx = n; t.busy = 1;
        t.ready = (s == stall[n]);
        tr.push_back(t);
      end
    end
    t = '{default: 0};
    t.done = 1; t.ready = 1;
    tr.push_back(t);
    last_c = tr.size() - 1;

    start = 1'b1;
    x_base = XW'(xb);
    w_base = WW'(wb);
    res_ready = noise ? 1'($urandom_range(0, 1)) : 1'b1;

    for (int c = 1; c <= last_c; c++) begin
      tick();
      start = (c == pulse_cyc) || (noise && c < last_c && $urandom_range(0, 5) == 0);
      if (noise) begin
        x_base = XW'($urandom);
        w_base = WW'($urandom);
      end
      res_ready = tr[c].ready;

      p = c - RD_LAT;
      ectrl = {tr[c].rd, 3'b000, tr[c].valid, tr[c].busy, tr[c].done};
      if (p >= 1 && tr[p].rd) begin
        ectrl[5] = 1'b1;
        ectrl[4] = (tr[p].i == 0);
        ectrl[3] = (tr[p].i == n_in - 1);
      end
      ex = XW'(tr[c].x);
      ew = WW'(tr[c].w);
      eidx = NW'(tr[c].idx);

      n_asrt++;
      if (o_ctrl !== ectrl) begin
        n_fail++;
        $display("FAIL ctrl cycle %0d: got rd/en/clr/last/valid/busy/done=%b expected %b", c, o_ctrl, ectrl);
      end
      n_asrt++;
      if (o_x !== ex) begin
        n_fail++;
        $display("FAIL x_addr cycle %0d: got %0d expected %0d", c, o_x, ex);
      end
      n_asrt++;
      if (o_w !== ew) begin
        n_fail++;
        $display("FAIL w_addr cycle %0d: got %0d expected %0d", c, o_w, ew);
      end
      if (tr[c].valid) begin
        n_asrt++;
        if (o_idx !== eidx) begin
          n_fail++;
          $display("FAIL res_idx cycle %0d: got %0d expected %0d", c, o_idx, eidx);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    rst = 1'b0;
    res_ready = 1'b1;
    x_base = '0;
    w_base = '0;
    for (int k = 0; k < 3; k++) begin
      start = 1'($urandom_range(0, 1));
      tick();
      n_asrt++;
      if ({o_ctrl, o_x, o_w, o_idx} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: got ctrl=%b x=%0d w=%0d idx=%0d expected all 0", o_ctrl, o_x, o_w, o_idx);
      end
    end
    start = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    sel = 1'b0;
    do_reset();
    run_layer(0, 0, 0, 1'b0, 0, 1'b0);
    tick();
  endtask

  task automatic test_backpressure();
    sel = 1'b0;
    do_reset();
    run_layer(0, 0, 5, 1'b0, 0, 1'b0);
    tick();
  endtask

  task automatic test_base_offsets();
    sel = 1'b0;
    do_reset();
    run_layer(100, 1000, 0, 1'b0, 0, 1'b0);
    tick();
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    do_reset();
    run_layer(0, 0, 0, 1'b0, 5, 1'b0);
    run_layer(7, 33, 0, 1'b0, 0, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    do_reset();
    start = 1'b1;
    x_base = 12'd50;
    w_base = 14'd200;
    for (int c = 1; c <= 5; c++) begin
      tick();
      start = 1'b0;
    end
    n_asrt++;
    if (o_ctrl !== 7'b0100010) begin
      n_fail++;
      $display("FAIL drain_before_reset: got ctrl=%b expected %b", o_ctrl, 7'b0100010);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int k = 0; k <= RD_LAT + 1; k++) begin
      n_asrt++;
      if ({o_ctrl, o_x, o_w, o_idx} !== '0) begin
        n_fail++;
        $display("FAIL reset_mid step %0d: got ctrl=%b x=%0d w=%0d idx=%0d expected all 0", k, o_ctrl, o_x, o_w, o_idx);
      end
      tick();
    end
    run_layer(3, 9, 1, 1'b0, 0, 1'b0);
    tick();
  endtask

  task automatic test_random();
    int xb, wb;
    sel = 1'b0;
    do_reset();
    for (int r = 0; r < 8; r++) begin
      xb = int'($urandom_range(0, (1 << XW) - A_IN));
      wb = int'($urandom_range(0, (1 << WW) - A_OUT * A_IN));
      run_layer(xb, wb, int'($urandom_range(0, 4)), 1'b1, 0, 1'b1);
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) tick();
    end
    tick();
  endtask

  task automatic test_single_term();
    int xb, wb;
    sel = 1'b1;
    do_reset();
    run_layer(0, 0, 0, 1'b0, 0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      xb = int'($urandom_range(0, (1 << XW) - B_IN));
      wb = int'($urandom_range(0, (1 << WW) - B_OUT * B_IN));
      run_layer(xb, wb, int'($urandom_range(0, 3)), 1'b1, 0, 1'b1);
    end
    tick();
  endtask

  initial begin
    sel = 1'b0;
    rst = 1'b0;
    start = 1'b0;
    res_ready = 1'b1;
    x_base = '0;
    w_base = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_base_offsets();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_single_term();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
